// File: rtl/ahb_slave_req_queue_if.sv
// ahb_slave_req_queue_if: AHB-Lite slave bus plus bridge request and read-return signals
interface ahb_slave_req_queue_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH = 4,
  parameter int NUM_SLV = 3
);
  logic Hwrite, Hreadyin;
  logic [1:0] Htrans;
  logic [ADDR_W-1:0] Haddr;
  logic [DATA_W-1:0] Hwdata;
  logic Hreadyout, Hresp;
  logic [DATA_W-1:0] Hrdata;
  logic req_valid, req_ready, req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [NUM_SLV-1:0] req_sel;
  logic rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic [$clog2(DEPTH+1)-1:0] fifo_count;
  logic buffer_full;
  modport slave(
    input Hwrite, Hreadyin, Htrans, Haddr, Hwdata, req_ready, rd_valid, rd_data,
    output Hreadyout, Hresp, Hrdata, req_valid, req_addr, req_wdata, req_write, req_sel,
    fifo_count, buffer_full
  );
  modport master(
    output Hwrite, Hreadyin, Htrans, Haddr, Hwdata, req_ready, rd_valid, rd_data,
    input Hreadyout, Hresp, Hrdata, req_valid, req_addr, req_wdata, req_write, req_sel,
    fifo_count, buffer_full
  );
endinterface

// File: rtl/ahb_slave_req_queue.sv
// ahb_slave_req_queue: AHB-Lite slave decoding APB regions and queueing requests toward the bridge
module ahb_slave_req_queue #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH = 4,
  parameter int NUM_SLV = 3,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000,
  parameter logic [ADDR_W-1:0] SLV_SIZE = 32'h0400_0000
) (
  input logic Hclk,
  input logic Hreset,
  ahb_slave_req_queue_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = ADDR_W + 4;
  localparam int EW = ADDR_W + DATA_W + 1 + NUM_SLV;
  typedef enum logic [2:0] {D_IDLE, D_WR, D_RD, D_ERR1, D_ERR2} state_t;
  state_t state, nxt, from_addr;
  logic valid, mapped, full, push, pop, wr, rd_done, rd_pushed, ready;
  logic [NUM_SLV-1:0] sel, a_sel;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] hrdata_q, wdata;
  logic [CW-1:0] count;
  logic [PW-1:0] wptr, rptr;
  logic [EW-1:0] mem [DEPTH];
  logic [EW-1:0] head;
  assign valid = bus.Hreadyin && (bus.Htrans inside {2'b10, 2'b11});
  // region bounds are widened by 4 bits so the top region limit cannot wrap
  for (genvar i = 0; i < NUM_SLV; i++) begin : g_dec
    localparam logic [LW-1:0] LO = {4'b0, BASE_ADDR} + {4'b0, SLV_SIZE} * LW'(i);
    assign sel[i] = {4'b0, bus.Haddr} >= LO && {4'b0, bus.Haddr} < LO + {4'b0, SLV_SIZE};
  end
  assign mapped = |sel;
  assign from_addr = !valid ? D_IDLE : !mapped ? D_ERR1 : bus.Hwrite ? D_WR : D_RD;
  assign full = count == CW'(DEPTH);
  assign pop = count != '0 && bus.req_ready;
  assign wr = state == D_WR;
  assign wdata = wr ? bus.Hwdata : '0;
  always_comb begin
    nxt = state;
    ready = 1'b1;
    push = 1'b0;
    rd_done = 1'b0;
    case (state)
      D_IDLE: nxt = from_addr;
      D_WR: begin
        push = !full;
        ready = !full;
        nxt = full ? D_WR : from_addr;
      end
      D_RD: begin
        push = !rd_pushed && !full;
        rd_done = rd_pushed && bus.rd_valid;
        ready = rd_done;
        nxt = rd_done ? from_addr : D_RD;
      end
      D_ERR1: begin
        ready = 1'b0;
        nxt = D_ERR2;
      end
      D_ERR2: nxt = from_addr;
      default: nxt = D_IDLE;
    endcase
  end
  assign bus.Hreadyout = ready;
  assign bus.Hresp = state == D_ERR1 || state == D_ERR2;
  assign bus.Hrdata = rd_done ? bus.rd_data : hrdata_q;
  assign head = count != '0 ? mem[rptr] : '0;
  assign {bus.req_addr, bus.req_wdata, bus.req_write, bus.req_sel} = head;
  assign bus.req_valid = count != '0;
  assign bus.fifo_count = count;
  assign bus.buffer_full = full;
  always_ff @(posedge Hclk or posedge Hreset)
    if (Hreset) begin
      state <= D_IDLE;
      rd_pushed <= 1'b0;
      a_addr <= '0;
      a_sel <= '0;
      hrdata_q <= '0;
      count <= '0;
      wptr <= '0;
      rptr <= '0;
    end else begin
      state <= nxt;
      rd_pushed <= state == D_RD && !rd_done && (rd_pushed || push);
      if (valid) begin
        a_addr <= bus.Haddr;
        a_sel <= sel;
      end
      if (rd_done) hrdata_q <= bus.rd_data;
      if (push) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  always_ff @(posedge Hclk)
    if (push) mem[wptr] <= {a_addr, wdata, wr, a_sel};
endmodule

// File: doc/ahb_slave_req_queue.md
Name: ahb_slave_req_queue

Overview:
Parametrised AHB-Lite slave front end for the AHB2APB bridge. It decodes a configurable number of APB slave regions and queues write and read requests in a DEPTH-entry FIFO toward the bridge. When the queue is full it stalls the AHB master with Hreadyout wait states. Unmapped addresses get a two-cycle ERROR response, and reads complete when the bridge returns read data.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
DEPTH, 4, FIFO entries; power of two, >=2
NUM_SLV, 3, APB slave regions; 1..8
BASE_ADDR, 32'h8000_0000, start of the first region
SLV_SIZE, 32'h0400_0000, bytes per region; regions are contiguous

Ports:
Hclk  in  1  clock
Hreset  in  1  asynchronous reset, active-high
Hwrite  in  1  AHB write flag
Hreadyin  in  1  AHB bus HREADY
Htrans  in  2  AHB transfer type
Haddr  in  ADDR_W  AHB address
Hwdata  in  DATA_W  AHB write data, data phase
Hreadyout  out  1  slave ready, low = wait state
Hresp  out  1  0 OKAY, 1 ERROR
Hrdata  out  DATA_W  read data
req_valid  out  1  FIFO head valid
req_ready  in  1  bridge accepts head
req_addr  out  ADDR_W  head address
req_wdata  out  DATA_W  head write data (0 for reads)
req_write  out  1  head write flag
req_sel  out  NUM_SLV  head one-hot slave select
rd_valid  in  1  bridge read-data strobe
rd_data  in  DATA_W  bridge read data
fifo_count  out  $clog2(DEPTH+1)  occupancy
buffer_full  out  1  fifo_count==DEPTH

Behaviour:
- Reset (async, Hreset=1, any time including mid-transfer):
  - FIFO, pointers, captured address phase and FSM cleared.
  - Outputs: Hreadyout=1, Hresp=0, Hrdata=0, req_valid=0, req_addr/req_wdata/req_write/req_sel=0, fifo_count=0, buffer_full=0.
- Transfer qualification: valid = Hreadyin && Htrans[1] (NONSEQ or SEQ).
- Address decode:
  - mapped = BASE_ADDR <= Haddr < BASE_ADDR+NUM_SLV*SLV_SIZE.
  - sel index = (Haddr-BASE_ADDR)/SLV_SIZE, output one-hot.
  - Compute the region limit at ADDR_W+4 bits so it cannot wrap.
- Address phase: on valid, register Haddr, Hwrite and sel, and enter the data-phase state next cycle.
- Data-phase FSM:
  - D_IDLE: Hreadyout=1, Hresp=0.
    - valid&&mapped&&Hwrite -> D_WR
    - valid&&mapped&&!Hwrite -> D_RD
    - valid&&!mapped -> D_ERR1
    - else stay. IDLE/BUSY transfers get a zero-wait OKAY with no capture.
  - D_WR:
    - If fifo_count<DEPTH: push {addr, Hwdata, 1, sel}; Hreadyout=1; next state from the current address phase, same rules as D_IDLE (back-to-back pipelining).
    - If fifo_count==DEPTH: Hreadyout=0, no push, stay. Full is checked on registered count only, so a same-cycle pop does not unblock the push until the next cycle.
  - D_RD:
    - Push {addr, 0, 0, sel} in the first cycle count<DEPTH. Hreadyout=0 until pushed.
    - Then hold Hreadyout=0 until rd_valid. In the rd_valid cycle: Hreadyout=1, Hrdata=rd_data, and next state from the current address phase.
    - Hrdata holds its last value otherwise.
    - rd_valid outside D_RD is ignored.
    - Reads are ordered behind all earlier queued writes.
  - D_ERR1: Hreadyout=0, Hresp=1, no push -> D_ERR2.
  - D_ERR2: Hreadyout=1, Hresp=1; next state from the current address phase.
- FIFO:
  - Pop when req_valid&&req_ready.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
  - req_* present the head combinationally and are forced to 0 when empty; req_valid = (count!=0).
  - req_ready while empty: no effect. Overflow and underflow are impossible by construction.
- No new address phase is accepted while Hreadyout=0, because the master sees Hreadyin low.

Test Plan:
- Reset, then single write Haddr=8000_0010, Hwdata=DEAD_BEEF, req_ready=1 -> 2 cycles after address phase: req_valid=1, req_sel=001, req_wdata=DEAD_BEEF; count returns to 0; Hreadyout never low.
- Six back-to-back NONSEQ writes, req_ready=0, DEPTH=4 -> count reaches 4, buffer_full=1, Hreadyout=0 in the 5th data phase. Raise req_ready -> pops in order; 5th and 6th pushed; no data loss; pointers wrap.
- Haddr=8C00_0000 NONSEQ write -> Hreadyout=0/Hresp=1, then Hreadyout=1/Hresp=1; FIFO unchanged. Next transfer to 8800_0004 -> req_sel=100.
- Read 8400_0008 queued behind 2 writes; rd_valid with rd_data=1234_5678 three cycles after the read pops -> Hreadyout low until that cycle; Hrdata=1234_5678; pop order is W, W, R.
- Push and pop in the same cycle at count=2 -> count stays 2; head advances.
- Assert Hreset during the D_RD wait with count=3 -> immediately Hreadyout=1, req_valid=0, count=0; first transfer after release completes normally.
